// File: rtl/riscv_pipeline_ctrl_unit_pkg.sv
// rtl/riscv_pipeline_ctrl_unit_pkg.sv - shared encodings and control bundle for the pipeline control unit
package riscv_pipeline_ctrl_unit_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_I_OP   = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [2:0] SRC_IMM_I = 3'd0;
  localparam logic [2:0] SRC_IMM_S = 3'd1;
  localparam logic [2:0] SRC_IMM_B = 3'd2;
  localparam logic [2:0] SRC_IMM_U = 3'd3;
  localparam logic [2:0] SRC_IMM_J = 3'd4;

  localparam logic [1:0] SRC_RD_ALU = 2'd0;
  localparam logic [1:0] SRC_RD_DME = 2'd1;
  localparam logic [1:0] SRC_RD_PC4 = 2'd2;
  localparam logic [1:0] SRC_RD_IMM = 2'd3;

  localparam logic SRC_ALU_A_RS1 = 1'b0;
  localparam logic SRC_ALU_A_PC  = 1'b1;
  localparam logic SRC_ALU_B_RS2 = 1'b0;
  localparam logic SRC_ALU_B_IMM = 1'b1;

  localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
  localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
  localparam logic [3:0] ALU_CTRL_AND  = 4'd9;

  localparam logic [1:0] FWD_SEL_REG = 2'b00;
  localparam logic [1:0] FWD_SEL_MEM = 2'b01;
  localparam logic [1:0] FWD_SEL_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       src_alu_a;
    logic       src_alu_b;
    logic [3:0] alu_ctrl;
    logic       mem_wr_en;
    logic       mem_is_load;
    logic [3:0] byte_sel;
    logic       reg_wr_en;
    logic [1:0] src_rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    valid:       1'b0,
    src_alu_a:   SRC_ALU_A_RS1,
    src_alu_b:   SRC_ALU_B_RS2,
    alu_ctrl:    ALU_CTRL_ADD,
    mem_wr_en:   1'b0,
    mem_is_load: 1'b0,
    byte_sel:    4'b1111,
    reg_wr_en:   1'b0,
    src_rd:      SRC_RD_ALU
  };

  // funct7 bit 5 only selects SUB for register-register ops; for I_OP it is immediate data
  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic funct7_5b,
                                            input logic is_reg);
    case (funct3)
      FUNCT3_ADD_SUB: return (is_reg && funct7_5b) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
      FUNCT3_SLL:     return ALU_CTRL_SLL;
      FUNCT3_SLT:     return ALU_CTRL_SLT;
      FUNCT3_SLTU:    return ALU_CTRL_SLTU;
      FUNCT3_XOR:     return ALU_CTRL_XOR;
      FUNCT3_SRL_SRA: return funct7_5b ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      FUNCT3_OR:      return ALU_CTRL_OR;
      default:        return ALU_CTRL_AND;
    endcase
  endfunction

  // access size lives in funct3[1:0]: byte, half, word
  function automatic logic [3:0] byte_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/riscv_pipeline_ctrl_unit_decode.sv
// rtl/riscv_pipeline_ctrl_unit_decode.sv - combinational RV32I control decoder
module riscv_ctrl_decode
  import riscv_pipeline_ctrl_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5b,
  output ctrl_t      ctrl,
  output logic [2:0] src_imm,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  // opcode table: start from a bubble and switch on only what each class needs
  always_comb begin
    ctrl     = CTRL_BUBBLE;
    src_imm  = SRC_IMM_I;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPCODE_R: begin
        ctrl.alu_ctrl  = alu_decode(funct3, funct7_5b, 1'b1);
        ctrl.reg_wr_en = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPCODE_I_OP: begin
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        ctrl.alu_ctrl  = alu_decode(funct3, funct7_5b, 1'b0);
        ctrl.reg_wr_en = 1'b1;
        rs1_used       = 1'b1;
      end
      OPCODE_LOAD: begin
        ctrl.src_alu_b   = SRC_ALU_B_IMM;
        ctrl.mem_is_load = 1'b1;
        ctrl.byte_sel    = byte_mask(funct3[1:0]);
        ctrl.reg_wr_en   = 1'b1;
        ctrl.src_rd      = SRC_RD_DME;
        rs1_used         = 1'b1;
      end
      OPCODE_STORE: begin
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        ctrl.mem_wr_en = 1'b1;
        ctrl.byte_sel  = byte_mask(funct3[1:0]);
        src_imm        = SRC_IMM_S;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPCODE_BRANCH: begin
        ctrl.src_alu_a = SRC_ALU_A_PC;
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        src_imm        = SRC_IMM_B;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPCODE_JAL: begin
        ctrl.src_alu_a = SRC_ALU_A_PC;
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        ctrl.reg_wr_en = 1'b1;
        ctrl.src_rd    = SRC_RD_PC4;
        src_imm        = SRC_IMM_J;
      end
      OPCODE_JALR: begin
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        ctrl.reg_wr_en = 1'b1;
        ctrl.src_rd    = SRC_RD_PC4;
        rs1_used       = 1'b1;
      end
      OPCODE_LUI: begin
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        ctrl.reg_wr_en = 1'b1;
        ctrl.src_rd    = SRC_RD_IMM;
        src_imm        = SRC_IMM_U;
      end
      OPCODE_AUIPC: begin
        ctrl.src_alu_a = SRC_ALU_A_PC;
        ctrl.src_alu_b = SRC_ALU_B_IMM;
        ctrl.reg_wr_en = 1'b1;
        src_imm        = SRC_IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    ctrl.valid = !illegal;
  end

endmodule

// File: rtl/riscv_pipeline_ctrl_unit.sv
// rtl/riscv_pipeline_ctrl_unit.sv - staged control, hazard detection and forwarding for the 5-stage pipeline
module riscv_pipeline_ctrl_unit
  import riscv_pipeline_ctrl_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_id_opcode,
  input  logic [2:0]            i_id_funct3,
  input  logic                  i_id_funct7_5b,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_valid,
  input  logic                  i_ex_redirect,
  input  logic                  i_mem_stall,
  output logic [2:0]            o_id_src_imm,
  output logic                  o_ex_src_alu_a,
  output logic                  o_ex_src_alu_b,
  output logic [3:0]            o_ex_alu_ctrl,
  output logic                  o_mem_wr_en,
  output logic [3:0]            o_mem_byte_sel,
  output logic                  o_mem_is_load,
  output logic                  o_wb_reg_wr_en,
  output logic [1:0]            o_wb_src_rd,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b,
  output logic                  o_stall_if,
  output logic                  o_stall_id,
  output logic                  o_flush_id
);

  typedef logic [REG_ADDR_W-1:0] addr_t;

  ctrl_t      dec_ctrl;
  logic [2:0] dec_src_imm;
  logic       dec_rs1_used, dec_rs2_used, dec_illegal;

  riscv_ctrl_decode u_decode (
    .opcode    (i_id_opcode),
    .funct3    (i_id_funct3),
    .funct7_5b (i_id_funct7_5b),
    .ctrl      (dec_ctrl),
    .src_imm   (dec_src_imm),
    .rs1_used  (dec_rs1_used),
    .rs2_used  (dec_rs2_used),
    .illegal   (dec_illegal)
  );

  // an empty or undecodable ID slot behaves exactly like a bubble, including its register uses
  logic  id_real, id_rs1_used, id_rs2_used;
  ctrl_t id_ctrl;
  addr_t id_rd;
  assign id_real     = i_id_valid && !dec_illegal;
  assign id_ctrl     = id_real ? dec_ctrl : CTRL_BUBBLE;
  assign id_rs1_used = id_real && dec_rs1_used;
  assign id_rs2_used = id_real && dec_rs2_used;
  assign id_rd       = id_ctrl.reg_wr_en ? i_id_rd : '0;

  ctrl_t      ex_ctrl;
  addr_t      ex_rd, ex_rs1, ex_rs2;
  logic       ex_rs1_used, ex_rs2_used;
  logic       mem_valid, mem_wr_en, mem_is_load, mem_reg_wr_en;
  logic [3:0] mem_byte_sel;
  logic [1:0] mem_src_rd;
  addr_t      mem_rd;
  logic       wb_valid, wb_reg_wr_en;
  logic [1:0] wb_src_rd;
  addr_t      wb_rd;

  // x0 never creates a dependency; only live writers count
  function automatic logic hit(input logic used, input addr_t rs, input addr_t rd,
                               input logic valid, input logic wr_en);
    return used && (rs != '0) && (rs == rd) && valid && wr_en;
  endfunction

  logic hz_ex, hz_mem, hz_wb, load_use, hazard_stall, stall, bubble_ex;
  assign hz_ex  = hit(id_rs1_used, i_id_rs1, ex_rd, ex_ctrl.valid, ex_ctrl.reg_wr_en)
               || hit(id_rs2_used, i_id_rs2, ex_rd, ex_ctrl.valid, ex_ctrl.reg_wr_en);
  assign hz_mem = hit(id_rs1_used, i_id_rs1, mem_rd, mem_valid, mem_reg_wr_en)
               || hit(id_rs2_used, i_id_rs2, mem_rd, mem_valid, mem_reg_wr_en);
  assign hz_wb  = hit(id_rs1_used, i_id_rs1, wb_rd, wb_valid, wb_reg_wr_en)
               || hit(id_rs2_used, i_id_rs2, wb_rd, wb_valid, wb_reg_wr_en);
  assign load_use     = hz_ex && ex_ctrl.mem_is_load;
  assign hazard_stall = FWD_EN ? load_use : (hz_ex || hz_mem || hz_wb);

  // memory freeze outranks redirect, which outranks a hazard stall
  always_comb begin
    stall      = 1'b0;
    o_flush_id = 1'b0;
    bubble_ex  = 1'b0;
    if (i_mem_stall) begin
      stall = 1'b1;
    end else if (i_ex_redirect) begin
      o_flush_id = 1'b1;
      bubble_ex  = 1'b1;
    end else if (hazard_stall) begin
      stall     = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  // forward selects for the EX instruction; the younger MEM result takes precedence over WB
  always_comb begin
    o_fwd_a = FWD_SEL_REG;
    o_fwd_b = FWD_SEL_REG;
    if (FWD_EN) begin
      if (hit(ex_rs1_used, ex_rs1, mem_rd, mem_valid, mem_reg_wr_en))  o_fwd_a = FWD_SEL_MEM;
      else if (hit(ex_rs1_used, ex_rs1, wb_rd, wb_valid, wb_reg_wr_en)) o_fwd_a = FWD_SEL_WB;
      if (hit(ex_rs2_used, ex_rs2, mem_rd, mem_valid, mem_reg_wr_en))  o_fwd_b = FWD_SEL_MEM;
      else if (hit(ex_rs2_used, ex_rs2, wb_rd, wb_valid, wb_reg_wr_en)) o_fwd_b = FWD_SEL_WB;
    end
  end

  // ID/EX register: loads a bubble on flush or hazard, holds during a memory freeze
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
    end else if (!i_mem_stall) begin
      ex_ctrl     <= bubble_ex ? CTRL_BUBBLE : id_ctrl;
      ex_rd       <= bubble_ex ? '0 : id_rd;
      ex_rs1      <= i_id_rs1;
      ex_rs2      <= i_id_rs2;
      ex_rs1_used <= !bubble_ex && id_rs1_used;
      ex_rs2_used <= !bubble_ex && id_rs2_used;
    end
  end

  // EX/MEM and MEM/WB registers advance together unless memory is frozen
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_valid     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_is_load   <= 1'b0;
      mem_byte_sel  <= 4'b1111;
      mem_reg_wr_en <= 1'b0;
      mem_src_rd    <= SRC_RD_ALU;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_reg_wr_en  <= 1'b0;
      wb_src_rd     <= SRC_RD_ALU;
      wb_rd         <= '0;
    end else if (!i_mem_stall) begin
      mem_valid     <= ex_ctrl.valid;
      mem_wr_en     <= ex_ctrl.mem_wr_en;
      mem_is_load   <= ex_ctrl.mem_is_load;
      mem_byte_sel  <= ex_ctrl.byte_sel;
      mem_reg_wr_en <= ex_ctrl.reg_wr_en;
      mem_src_rd    <= ex_ctrl.src_rd;
      mem_rd        <= ex_rd;
      wb_valid      <= mem_valid;
      wb_reg_wr_en  <= mem_reg_wr_en;
      wb_src_rd     <= mem_src_rd;
      wb_rd         <= mem_rd;
    end
  end

  assign o_id_src_imm   = dec_src_imm;
  assign o_ex_src_alu_a = ex_ctrl.src_alu_a;
  assign o_ex_src_alu_b = ex_ctrl.src_alu_b;
  assign o_ex_alu_ctrl  = ex_ctrl.alu_ctrl;
  assign o_mem_wr_en    = mem_wr_en;
  assign o_mem_byte_sel = mem_byte_sel;
  assign o_mem_is_load  = mem_is_load;
  assign o_wb_reg_wr_en = wb_reg_wr_en;
  assign o_wb_src_rd    = wb_src_rd;
  assign o_wb_rd        = wb_rd;
  assign o_stall_if     = stall;
  assign o_stall_id     = stall;

endmodule

// File: doc/riscv_pipeline_ctrl_unit.md
# riscv_pipeline_ctrl_unit

Staged control unit for the 5-stage RV32I pipeline. Decodes the ID-stage instruction into the standard control bundle, carries it through ID/EX, EX/MEM and MEM/WB control registers, and resolves data and control hazards. It replaces the purely combinational decoder plus ad-hoc stage registers. It adds load-use stall, branch/jump flush, a memory-stall freeze, and a selectable forwarding or stall-only hazard mode.

## Interface
- REG_ADDR_W, 5, register-address width (4 for RV32E)
- FWD_EN, 1, 1 = forwarding with load-use stall; 0 = stall on any RAW hazard
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_id_opcode / i_id_funct3 / i_id_funct7_5b  in  7/3/1  ID-stage instruction fields
- i_id_rs1, i_id_rs2, i_id_rd  in  REG_ADDR_W  ID-stage register addresses
- i_id_valid  in  1  ID holds a real instruction
- i_ex_redirect  in  1  EX-stage branch taken or jump; PC being redirected
- i_mem_stall  in  1  data memory not ready; freeze whole pipeline
- o_id_src_imm  out  3  combinational immediate select for ID
- o_ex_src_alu_a, o_ex_src_alu_b  out  1  registered EX operand selects
- o_ex_alu_ctrl  out  4  registered ALU op
- o_mem_wr_en  out  1  registered store enable
- o_mem_byte_sel  out  4  registered byte mask
- o_mem_is_load  out  1  registered load flag
- o_wb_reg_wr_en  out  1  registered register-file write enable
- o_wb_src_rd  out  2  registered rd source (ALU/DME/PC4/IMM)
- o_wb_rd  out  REG_ADDR_W  WB destination
- o_fwd_a, o_fwd_b  out  2  EX operand forward select: 00 regfile, 01 MEM result, 10 WB result
- o_stall_if, o_stall_id  out  1  hold PC / IF-ID register
- o_flush_id  out  1  kill the IF-ID register content

## Operation
- Decode tables for imm select, ALU select, ALU control and byte select use the shared configs.
- Loads select `SRC_RD_DME`. JAL and JALR select PC4. LUI selects IMM. All others select ALU.
- A stage counts as a bubble when it holds an unknown opcode or when `i_id_valid=0`. A bubble carries all write enables 0, `alu_ctrl=ALU_CTRL_ADD`, `byte_sel=4'b1111`, `valid=0`.
- rs1 is used by R, I_OP, LOAD, STORE, BRANCH and JALR. rs2 is used by R, STORE and BRANCH.
- A hazard match requires all of:
  - the register is used;
  - the address is nonzero;
  - it equals a later stage's rd;
  - that stage is valid and has `reg_wr_en=1`.
- FWD_EN=1:
  - EX-stage load matching ID → load-use hazard. Assert `o_stall_if`/`o_stall_id` one cycle and insert a bubble into EX.
  - Forward selects are computed for the EX-stage instruction. A MEM match gives 01. A WB match gives 10. If both match, MEM wins.
- FWD_EN=0: stall while any EX, MEM or WB match exists. `o_fwd_a` and `o_fwd_b` are tied to 00.
- `i_ex_redirect` effects:
  - assert `o_flush_id`;
  - EX is loaded with a bubble next cycle;
  - MEM and WB advance normally.
- Priority: `i_mem_stall` > `i_ex_redirect` > hazard stall.
- Redirect during a load-use stall: the flush wins and the stall deasserts.
- `i_mem_stall=1` effects:
  - all stage registers hold;
  - `o_stall_if`=`o_stall_id`=1;
  - `o_flush_id=0`;
  - a redirect arriving during the freeze is re-evaluated when the freeze lifts. EX still holds the branch, so the redirect stays asserted.

## Timing
- ID→EX, EX→MEM and MEM→WB each take one cycle. Each control field appears one cycle after the stage before it.
- `o_id_src_imm`, the stall outputs, `o_flush_id` and the `o_fwd_*` outputs are combinational from the current stage state and inputs.
- Reset values:
  - all stage valid bits 0;
  - all write enables 0;
  - `o_mem_is_load=0`;
  - `o_mem_byte_sel=4'b1111`;
  - `o_ex_alu_ctrl=ALU_CTRL_ADD`;
  - `o_wb_src_rd=SRC_RD_ALU`;
  - `o_wb_rd=0`;
  - `o_fwd_*=00`;
  - stalls and flush 0.
- Reset mid-operation clears every stage asynchronously. The first instruction presented after reset deasserts enters EX on the next edge.
- Load-use costs exactly one bubble. In FWD_EN=0 mode, a dependent instruction stalls 3 cycles behind its producer. It leaves ID once the producer has left WB.

## Structure
- Shared package or configs file holds:
  - OPCODE_*, FUNCT3_*, SRC_IMM_*, SRC_RD_*, SRC_ALU_*, ALU_CTRL_* (existing);
  - new FWD_SEL_REG/MEM/WB codes (2 bit).
- One sub-module: `riscv_ctrl_decode`, the combinational decoder. It outputs the control bundle plus rs1_used/rs2_used and an illegal flag.
- Hazard and forwarding logic stay in the top.

## Test plan
- `lw x5` then `add x6,x5,x1`, FWD_EN=1:
  - `o_stall_if`=1 for one cycle;
  - EX bubble (`o_ex_alu_ctrl`=ADD, valid 0);
  - then `o_fwd_a`=10.
- `add x5`, then `sub x7,x5,x5`, FWD_EN=1 → `o_fwd_a`=`o_fwd_b`=01 with no stall. Then `or x8,x0,x0` → no forward, since address 0 never matches.
- `beq` taken with `i_ex_redirect`=1, with a load-use hazard also pending:
  - `o_flush_id`=1 and stall 0;
  - the next cycle shows EX as a bubble;
  - MEM holds the prior store with `o_mem_wr_en`=1.
- `i_mem_stall`=1 for 3 cycles mid-stream → all registered outputs unchanged for 3 edges. The stall outputs are 1 throughout.
- FWD_EN=0, `addi x3` then `add x4,x3,x3` → `o_stall_id`=1 for exactly 3 cycles. `o_fwd_*` stay 00.
- Assert `i_rst` asynchronously with all stages valid → every output shows its reset value before the next clock edge. `sb` after reset gives `o_mem_byte_sel`=4'b0001 two cycles after ID.
